// File: rtl/wb_write_arbiter.sv
// Register-file write-port arbiter: ALU results pass straight through, MDU results queue and
// drain in idle ALU slots. Define WB_BYPASS_EN to add forwarding outputs from the output register.
module wb_write_arbiter #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned DW         = 32,
  parameter int unsigned AW         = 5
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        i_alu_we,
  input  logic [AW-1:0]               i_alu_waddr,
  input  logic [DW-1:0]               i_alu_wdata,
  input  logic                        i_mdu_valid,
  output logic                        o_mdu_ready,
  input  logic [AW-1:0]               i_mdu_waddr,
  input  logic [DW-1:0]               i_mdu_wdata,
  input  logic                        i_flush,
  output logic                        o_we,
  output logic [AW-1:0]               o_waddr,
  output logic [DW-1:0]               o_wdata,
  input  logic [AW-1:0]               i_raddr1,
  input  logic [AW-1:0]               i_raddr2,
  output logic                        o_pend1,
  output logic                        o_pend2,
`ifdef WB_BYPASS_EN
  output logic                        o_byp_hit1,
  output logic                        o_byp_hit2,
  output logic [DW-1:0]               o_byp_data1,
  output logic [DW-1:0]               o_byp_data2,
`endif
  output logic [$clog2(FIFO_DEPTH):0] o_fifo_count
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;

  logic                  we_q, we_d;
  logic [AW-1:0]         waddr_q, waddr_d;
  logic [DW-1:0]         wdata_q, wdata_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [FIFO_DEPTH-1:0] vld_q, vld_d;
  logic [AW-1:0]         addr_q [FIFO_DEPTH];
  logic [DW-1:0]         data_q [FIFO_DEPTH];

  logic alu_req_c, ready_c, push_c, pop_c;
  logic qhit1_c, qhit2_c, ohit1_c, ohit2_c;

  // r0 writes are dropped at the source; a flush suppresses both pop and push
  assign alu_req_c = i_alu_we & (i_alu_waddr != '0);
  assign ready_c   = (count_q < CW'(FIFO_DEPTH));
  assign push_c    = i_mdu_valid & ready_c & (i_mdu_waddr != '0) & ~i_flush;
  assign pop_c     = ~alu_req_c & (count_q != '0) & ~i_flush;

  always_comb begin
    we_d     = 1'b0;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    vld_d    = vld_q;
    if (alu_req_c) begin
      we_d    = 1'b1;
      waddr_d = i_alu_waddr;
      wdata_d = i_alu_wdata;
    end else if (pop_c) begin
      we_d    = 1'b1;
      waddr_d = addr_q[rd_ptr_q];
      wdata_d = data_q[rd_ptr_q];
    end
    if (i_flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
      vld_d    = '0;
    end else begin
      if (pop_c) begin
        vld_d[rd_ptr_q] = 1'b0;
        rd_ptr_d        = rd_ptr_q + PW'(1);
      end
      if (push_c) begin
        vld_d[wr_ptr_q] = 1'b1;
        wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      case ({push_c, pop_c})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      we_q     <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      vld_q    <= '0;
    end else begin
      we_q     <= we_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      vld_q    <= vld_d;
    end
  end

  // Payload storage needs no reset; occupancy is tracked by vld_q
  always_ff @(posedge clk) begin
    if (push_c) begin
      addr_q[wr_ptr_q] <= i_mdu_waddr;
      data_q[wr_ptr_q] <= i_mdu_wdata;
    end
  end

  always_comb begin
    qhit1_c = 1'b0;
    qhit2_c = 1'b0;
    for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
      if (vld_q[PW'(i)] && (addr_q[PW'(i)] == i_raddr1)) qhit1_c = 1'b1;
      if (vld_q[PW'(i)] && (addr_q[PW'(i)] == i_raddr2)) qhit2_c = 1'b1;
    end
  end

  assign ohit1_c = we_q & (waddr_q == i_raddr1) & (i_raddr1 != '0);
  assign ohit2_c = we_q & (waddr_q == i_raddr2) & (i_raddr2 != '0);

`ifdef WB_BYPASS_EN
  assign o_byp_hit1  = ohit1_c;
  assign o_byp_hit2  = ohit2_c;
  assign o_byp_data1 = ohit1_c ? wdata_q : '0;
  assign o_byp_data2 = ohit2_c ? wdata_q : '0;
  assign o_pend1     = (i_raddr1 != '0) & qhit1_c;
  assign o_pend2     = (i_raddr2 != '0) & qhit2_c;
`else
  assign o_pend1     = (i_raddr1 != '0) & (qhit1_c | ohit1_c);
  assign o_pend2     = (i_raddr2 != '0) & (qhit2_c | ohit2_c);
`endif

  assign o_we         = we_q;
  assign o_waddr      = waddr_q;
  assign o_wdata      = wdata_q;
  assign o_mdu_ready  = ready_c;
  assign o_fifo_count = count_q;

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Bench for wb_write_arbiter: directed table, corner-case sequences and randomized traffic
// against a queue-based reference model. Honours WB_BYPASS_EN.
module tb_wb_write_arbiter;

  logic        clk;
  logic        reset_n;
  logic        alu_we;
  logic [4:0]  alu_waddr;
  logic [31:0] alu_wdata;
  logic        mdu_valid;
  logic        mdu_ready;
  logic [4:0]  mdu_waddr;
  logic [31:0] mdu_wdata;
  logic        flush;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [4:0]  raddr1, raddr2;
  logic        pend1, pend2;
  logic [2:0]  fifo_count;
`ifdef WB_BYPASS_EN
  logic        byp_hit1, byp_hit2;
  logic [31:0] byp_data1, byp_data2;
`endif

  wb_write_arbiter #(.FIFO_DEPTH(4), .DW(32), .AW(5)) dut (
    .clk(clk), .reset_n(reset_n),
    .i_alu_we(alu_we), .i_alu_waddr(alu_waddr), .i_alu_wdata(alu_wdata),
    .i_mdu_valid(mdu_valid), .o_mdu_ready(mdu_ready),
    .i_mdu_waddr(mdu_waddr), .i_mdu_wdata(mdu_wdata),
    .i_flush(flush),
    .o_we(we), .o_waddr(waddr), .o_wdata(wdata),
    .i_raddr1(raddr1), .i_raddr2(raddr2),
    .o_pend1(pend1), .o_pend2(pend2),
`ifdef WB_BYPASS_EN
    .o_byp_hit1(byp_hit1), .o_byp_hit2(byp_hit2),
    .o_byp_data1(byp_data1), .o_byp_data2(byp_data2),
`endif
    .o_fifo_count(fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  typedef struct packed {
    logic [4:0]  a;
    logic [31:0] d;
  } ent_t;

  ent_t        mq[$];
  logic        m_we;
  logic [4:0]  m_waddr;
  logic [31:0] m_wdata;

  typedef struct {
    logic        alu_we;
    logic [4:0]  alu_a;
    logic [31:0] alu_d;
    logic        mdu_v;
    logic [4:0]  mdu_a;
    logic [31:0] mdu_d;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic        e_we;
    logic [4:0]  e_a;
    logic [31:0] e_d;
    logic [2:0]  e_cnt;
    logic        e_p1;
    logic        e_p2;
  } vec_t;

  vec_t tbl[9];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic m_qhit(input logic [4:0] ra);
    logic hit;
    hit = 1'b0;
    foreach (mq[i]) if (mq[i].a == ra) hit = 1'b1;
    return hit;
  endfunction

  function automatic logic m_ohit(input logic [4:0] ra);
    return m_we && (m_waddr == ra) && (ra != 5'd0);
  endfunction

  function automatic logic m_pend(input logic [4:0] ra);
    if (ra == 5'd0) return 1'b0;
`ifdef WB_BYPASS_EN
    return m_qhit(ra);
`else
    return m_qhit(ra) || m_ohit(ra);
`endif
  endfunction

  task automatic model_reset();
    mq.delete();
    m_we    = 1'b0;
    m_waddr = 5'd0;
    m_wdata = 32'd0;
  endtask

  // One clock of the arbiter's contract: ALU wins, else drain oldest, push only if room before pop
  task automatic model_update();
    ent_t e;
    bit   room;
    room = (mq.size() < 4);
    if (alu_we && alu_waddr != 5'd0) begin
      m_we = 1'b1; m_waddr = alu_waddr; m_wdata = alu_wdata;
    end else if (!flush && mq.size() != 0) begin
      e = mq.pop_front();
      m_we = 1'b1; m_waddr = e.a; m_wdata = e.d;
    end else begin
      m_we = 1'b0;
    end
    if (flush) mq.delete();
    else if (mdu_valid && room && mdu_waddr != 5'd0) mq.push_back('{a: mdu_waddr, d: mdu_wdata});
  endtask

  task automatic model_check();
    chk("we", 64'(we), 64'(m_we));
    chk("waddr", 64'(waddr), 64'(m_waddr));
    chk("wdata", 64'(wdata), 64'(m_wdata));
    chk("count", 64'(fifo_count), 64'(mq.size()));
    chk("ready", 64'(mdu_ready), 64'(mq.size() < 4));
    chk("pend1", 64'(pend1), 64'(m_pend(raddr1)));
    chk("pend2", 64'(pend2), 64'(m_pend(raddr2)));
`ifdef WB_BYPASS_EN
    chk("byp_hit1", 64'(byp_hit1), 64'(m_ohit(raddr1)));
    chk("byp_hit2", 64'(byp_hit2), 64'(m_ohit(raddr2)));
    chk("byp_data1", 64'(byp_data1), 64'(m_ohit(raddr1) ? m_wdata : 32'd0));
    chk("byp_data2", 64'(byp_data2), 64'(m_ohit(raddr2) ? m_wdata : 32'd0));
`endif
  endtask

  task automatic settle();
    #1;
    model_check();
  endtask

  task automatic clk_edge();
    @(posedge clk);
    if (!reset_n) model_reset();
    else model_update();
    @(negedge clk);
  endtask

  task automatic tick();
    settle();
    clk_edge();
  endtask

  task automatic idle_inputs();
    alu_we = 1'b0; alu_waddr = 5'd0; alu_wdata = 32'd0;
    mdu_valid = 1'b0; mdu_waddr = 5'd0; mdu_wdata = 32'd0;
    flush = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0;
    idle_inputs();
    raddr1 = 5'd0; raddr2 = 5'd0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    settle();
    chk("rst_we", 64'(we), 64'd0);
    chk("rst_waddr", 64'(waddr), 64'd0);
    chk("rst_wdata", 64'(wdata), 64'd0);
    chk("rst_count", 64'(fifo_count), 64'd0);
    chk("rst_ready", 64'(mdu_ready), 64'd1);
    clk_edge();

    // ALU single write, then ALU stream starving a queued MDU result
    tbl[0] = '{1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, 32'h0, 5'd7, 5'd5, 1'b0, 5'd0, 32'h0,    3'd0, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0, 5'd7, 5'd5, 1'b1, 5'd5, 32'h1234, 3'd0, 1'b0, 1'b1};
    tbl[2] = '{1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0, 5'd7, 5'd5, 1'b0, 5'd5, 32'h1234, 3'd0, 1'b0, 1'b0};
    tbl[3] = '{1'b1, 5'd1, 32'h11,   1'b1, 5'd7, 32'hA, 5'd7, 5'd5, 1'b0, 5'd5, 32'h1234, 3'd0, 1'b0, 1'b0};
    tbl[4] = '{1'b1, 5'd2, 32'h22,   1'b0, 5'd0, 32'h0, 5'd7, 5'd5, 1'b1, 5'd1, 32'h11,   3'd1, 1'b1, 1'b0};
    tbl[5] = '{1'b1, 5'd3, 32'h33,   1'b0, 5'd0, 32'h0, 5'd7, 5'd5, 1'b1, 5'd2, 32'h22,   3'd1, 1'b1, 1'b0};
    tbl[6] = '{1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0, 5'd7, 5'd5, 1'b1, 5'd3, 32'h33,   3'd1, 1'b1, 1'b0};
    tbl[7] = '{1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0, 5'd7, 5'd5, 1'b1, 5'd7, 32'hA,    3'd0, 1'b1, 1'b0};
    tbl[8] = '{1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0, 5'd7, 5'd5, 1'b0, 5'd7, 32'hA,    3'd0, 1'b0, 1'b0};
    for (int i = 0; i < 9; i++) begin
      alu_we = tbl[i].alu_we; alu_waddr = tbl[i].alu_a; alu_wdata = tbl[i].alu_d;
      mdu_valid = tbl[i].mdu_v; mdu_waddr = tbl[i].mdu_a; mdu_wdata = tbl[i].mdu_d;
      raddr1 = tbl[i].ra1; raddr2 = tbl[i].ra2;
      settle();
      chk($sformatf("tbl%0d_we", i), 64'(we), 64'(tbl[i].e_we));
      chk($sformatf("tbl%0d_waddr", i), 64'(waddr), 64'(tbl[i].e_a));
      chk($sformatf("tbl%0d_wdata", i), 64'(wdata), 64'(tbl[i].e_d));
      chk($sformatf("tbl%0d_count", i), 64'(fifo_count), 64'(tbl[i].e_cnt));
`ifndef WB_BYPASS_EN
      chk($sformatf("tbl%0d_pend1", i), 64'(pend1), 64'(tbl[i].e_p1));
      chk($sformatf("tbl%0d_pend2", i), 64'(pend2), 64'(tbl[i].e_p2));
`endif
      clk_edge();
    end
    idle_inputs();

    // Fill the queue behind a busy ALU, hold a 5th entry, then drain in order
    for (int i = 0; i < 4; i++) begin
      alu_we = 1'b1; alu_waddr = 5'd20; alu_wdata = 32'(i);
      mdu_valid = 1'b1; mdu_waddr = 5'(8 + i); mdu_wdata = 32'(16'h100 + i);
      tick();
    end
    mdu_waddr = 5'd12; mdu_wdata = 32'h10C;
    settle();
    chk("full_count", 64'(fifo_count), 64'd4);
    chk("full_ready", 64'(mdu_ready), 64'd0);
    clk_edge();
    alu_we = 1'b0;
    settle();
    chk("full_hold_ready", 64'(mdu_ready), 64'd0);
    clk_edge();
    for (int k = 0; k < 5; k++) begin
      settle();
      chk($sformatf("drain%0d_we", k), 64'(we), 64'd1);
      chk($sformatf("drain%0d_waddr", k), 64'(waddr), 64'(8 + k));
      if (k == 0) chk("drain_ready", 64'(mdu_ready), 64'd1);
      clk_edge();
      mdu_valid = 1'b0;
    end
    idle_inputs();

    // Writes aimed at r0 never reach the port or the queue
    raddr1 = 5'd0;
    for (int i = 0; i < 3; i++) begin
      alu_we = 1'b1; alu_waddr = 5'd0; alu_wdata = 32'hDEAD;
      mdu_valid = 1'b1; mdu_waddr = 5'd0; mdu_wdata = 32'hBEEF;
      settle();
      if (i > 0) chk("r0_we", 64'(we), 64'd0);
      chk("r0_count", 64'(fifo_count), 64'd0);
      chk("r0_ready", 64'(mdu_ready), 64'd1);
      clk_edge();
    end
    idle_inputs();
    tick();

    // Flush with two entries queued and a concurrent push
    raddr1 = 5'd13;
    alu_we = 1'b1; alu_waddr = 5'd20; alu_wdata = 32'h55;
    mdu_valid = 1'b1; mdu_waddr = 5'd13; mdu_wdata = 32'h13;
    tick();
    mdu_waddr = 5'd14; mdu_wdata = 32'h14;
    tick();
    alu_we = 1'b0; flush = 1'b1; mdu_waddr = 5'd15; mdu_wdata = 32'h15;
    settle();
    chk("preflush_pend1", 64'(pend1), 64'd1);
    chk("preflush_count", 64'(fifo_count), 64'd2);
    clk_edge();
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("postflush_we", 64'(we), 64'd0);
      chk("postflush_count", 64'(fifo_count), 64'd0);
      chk("postflush_pend1", 64'(pend1), 64'd0);
      clk_edge();
    end

    // Asynchronous reset with three entries queued
    for (int i = 0; i < 3; i++) begin
      alu_we = 1'b1; alu_waddr = 5'd21; alu_wdata = 32'h77;
      mdu_valid = 1'b1; mdu_waddr = 5'(13 + i); mdu_wdata = 32'(i);
      tick();
    end
    idle_inputs();
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_we", 64'(we), 64'd0);
    chk("arst_count", 64'(fifo_count), 64'd0);
    chk("arst_ready", 64'(mdu_ready), 64'd1);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("postrst_we", 64'(we), 64'd0);
      clk_edge();
    end

`ifdef WB_BYPASS_EN
    alu_we = 1'b1; alu_waddr = 5'd9; alu_wdata = 32'hBEEF;
    raddr2 = 5'd9;
    tick();
    idle_inputs();
    settle();
    chk("byp_hit2_r9", 64'(byp_hit2), 64'd1);
    chk("byp_data2_r9", 64'(byp_data2), 64'hBEEF);
    chk("byp_pend2_r9", 64'(pend2), 64'd0);
    clk_edge();
`endif

    // Randomized traffic against the reference model
    for (int c = 0; c < 3000; c++) begin
      alu_we    = 1'($urandom_range(0, 1));
      alu_waddr = 5'($urandom_range(0, 7));
      alu_wdata = $urandom;
      mdu_valid = ($urandom_range(0, 2) != 0);
      mdu_waddr = 5'($urandom_range(0, 7));
      mdu_wdata = $urandom;
      flush     = ($urandom_range(0, 31) == 0);
      raddr1    = 5'($urandom_range(0, 7));
      raddr2    = 5'($urandom_range(0, 7));
      tick();
    end
    idle_inputs();
    settle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
